// File: rtl/vscale_hazard_unit.sv
// ---------------------------------------------------------------------------
// vscale_hazard_unit
//
// Hazard, bypass and stall controller for a vscale pipeline with DEPTH stages
// after DX. Each post-DX stage carries a small write descriptor (valid, wr, rd,
// lat). Sources in DX are matched against these descriptors to pick the
// youngest bypassable producer, or to stall when the producer's result is not
// ready yet. Multi-cycle (mul/div) results are tracked by a per-register
// scoreboard instead, since they never travel down the write path.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   issue_valid           DX holds a valid instruction
//   rs1_addr, rs2_addr    DX source registers
//   uses_rs1, uses_rs2    DX instruction reads rs1 / rs2
//   wr_reg_DX, rd_DX      DX instruction writes rd_DX
//   lat_DX                first entry index at which the result is bypassable
//   md_op_DX              DX instruction goes to the multi-cycle unit
//   stall_ext             downstream stall, freezes every entry
//   flush                 kill all entries (redirect / exception)
//   md_done, md_rd        multi-cycle unit completes, writing md_rd
//   stall_DX              hold DX this cycle
//   issue_fire            DX instruction accepted this cycle
//   bypass_rs1_sel/rs2    0 = regfile, i+1 = entry i
//   wr_reg_WB             last entry writes the regfile this cycle
//   reg_to_wr_WB          destination of the last entry
//   md_busy               multi-cycle unit occupied
// ---------------------------------------------------------------------------
module vscale_hazard_unit #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DEPTH          = 2,
    localparam int LAT_WIDTH     = $clog2(DEPTH + 1),
    localparam int SEL_WIDTH     = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      issue_valid,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr,
    input  logic                      uses_rs1,
    input  logic                      uses_rs2,
    input  logic                      wr_reg_DX,
    input  logic [REG_ADDR_WIDTH-1:0] rd_DX,
    input  logic [LAT_WIDTH-1:0]      lat_DX,
    input  logic                      md_op_DX,
    input  logic                      stall_ext,
    input  logic                      flush,
    input  logic                      md_done,
    input  logic [REG_ADDR_WIDTH-1:0] md_rd,
    output logic                      stall_DX,
    output logic                      issue_fire,
    output logic [SEL_WIDTH-1:0]      bypass_rs1_sel,
    output logic [SEL_WIDTH-1:0]      bypass_rs2_sel,
    output logic                      wr_reg_WB,
    output logic [REG_ADDR_WIDTH-1:0] reg_to_wr_WB,
    output logic                      md_busy
);

    localparam int NUM_REGS = 1 << REG_ADDR_WIDTH;
    localparam logic [LAT_WIDTH-1:0] MAX_LAT = LAT_WIDTH'(DEPTH - 1);

    // Per-entry write descriptors.
    logic                      ent_valid_reg [DEPTH];
    logic                      ent_wr_reg    [DEPTH];
    logic [REG_ADDR_WIDTH-1:0] ent_rd_reg    [DEPTH];
    logic [LAT_WIDTH-1:0]      ent_lat_reg   [DEPTH];

    logic                      ent_valid_next [DEPTH];
    logic                      ent_wr_next    [DEPTH];
    logic [REG_ADDR_WIDTH-1:0] ent_rd_next    [DEPTH];
    logic [LAT_WIDTH-1:0]      ent_lat_next   [DEPTH];

    // What each entry would receive on an advance.
    logic                      src_valid [DEPTH];
    logic                      src_wr    [DEPTH];
    logic [REG_ADDR_WIDTH-1:0] src_rd    [DEPTH];
    logic [LAT_WIDTH-1:0]      src_lat   [DEPTH];

    logic [NUM_REGS-1:0]       sb_reg;
    logic [NUM_REGS-1:0]       sb_next;
    logic                      md_busy_reg;
    logic                      md_busy_next;

    logic [SEL_WIDTH:0]        rs1_lookup;
    logic [SEL_WIDTH:0]        rs2_lookup;
    logic                      raw_stall;
    logic                      sb_stall;
    logic [LAT_WIDTH-1:0]      lat_clamped;

    assign lat_clamped = (lat_DX > MAX_LAT) ? MAX_LAT : lat_DX;

    // Returns {stall, sel}. The loop walks from youngest (entry 0) to oldest
    // and only the first producer of the register is considered: an older
    // write to the same register is dead for this consumer.
    function automatic logic [SEL_WIDTH:0] src_lookup(
        input logic                      use_src,
        input logic [REG_ADDR_WIDTH-1:0] addr
    );
        logic [SEL_WIDTH:0] res;
        logic               found;
        res   = '0;
        found = 1'b0;
        if (use_src && addr != '0) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!found && ent_valid_reg[i] && ent_wr_reg[i] &&
                    ent_rd_reg[i] != '0 && ent_rd_reg[i] == addr) begin
                    found = 1'b1;
                    if (ent_lat_reg[i] <= LAT_WIDTH'(i))
                        res = {1'b0, SEL_WIDTH'(i + 1)};
                    else
                        res = {1'b1, {SEL_WIDTH{1'b0}}};
                end
            end
        end
        return res;
    endfunction

    always_comb begin
        rs1_lookup = src_lookup(uses_rs1, rs1_addr);
        rs2_lookup = src_lookup(uses_rs2, rs2_addr);
        raw_stall  = rs1_lookup[SEL_WIDTH] | rs2_lookup[SEL_WIDTH];
    end

    // Scoreboard conflicts: RAW on an outstanding md result, WAW against it,
    // or a second md op while the unit is occupied.
    always_comb begin
        sb_stall = (uses_rs1 && rs1_addr != '0 && sb_reg[rs1_addr]) ||
                   (uses_rs2 && rs2_addr != '0 && sb_reg[rs2_addr]) ||
                   ((wr_reg_DX || md_op_DX) && sb_reg[rd_DX]) ||
                   (md_op_DX && md_busy_reg);
    end

    assign stall_DX       = (issue_valid && (raw_stall || sb_stall)) || stall_ext;
    assign issue_fire     = issue_valid && !stall_DX;
    assign bypass_rs1_sel = rs1_lookup[SEL_WIDTH-1:0];
    assign bypass_rs2_sel = rs2_lookup[SEL_WIDTH-1:0];
    assign wr_reg_WB      = ent_valid_reg[DEPTH-1] && ent_wr_reg[DEPTH-1] && !stall_ext;
    assign reg_to_wr_WB   = ent_rd_reg[DEPTH-1];
    assign md_busy        = md_busy_reg;

    // Entry next-state: flush beats stall_ext, which beats advance.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        if (gi == 0) begin : g_head
            // A non-firing cycle inserts a bubble; md ops never write here.
            assign src_valid[gi] = issue_fire;
            assign src_wr[gi]    = wr_reg_DX && !md_op_DX;
            assign src_rd[gi]    = rd_DX;
            assign src_lat[gi]   = lat_clamped;
        end else begin : g_tail
            assign src_valid[gi] = ent_valid_reg[gi-1];
            assign src_wr[gi]    = ent_wr_reg[gi-1];
            assign src_rd[gi]    = ent_rd_reg[gi-1];
            assign src_lat[gi]   = ent_lat_reg[gi-1];
        end

        assign ent_valid_next[gi] = flush     ? 1'b0 :
                                    stall_ext ? ent_valid_reg[gi] : src_valid[gi];
        assign ent_wr_next[gi]    = (flush || stall_ext) ? ent_wr_reg[gi]  : src_wr[gi];
        assign ent_rd_next[gi]    = (flush || stall_ext) ? ent_rd_reg[gi]  : src_rd[gi];
        assign ent_lat_next[gi]   = (flush || stall_ext) ? ent_lat_reg[gi] : src_lat[gi];
    end

    // Completion clears first so a same-cycle md issue still claims its rd.
    always_comb begin
        sb_next      = sb_reg;
        md_busy_next = md_busy_reg;
        if (md_done) begin
            sb_next[md_rd] = 1'b0;
            md_busy_next   = 1'b0;
        end
        if (issue_fire && md_op_DX) begin
            sb_next[rd_DX] = 1'b1;
            md_busy_next   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_valid_reg[i] <= 1'b0;
                ent_wr_reg[i]    <= 1'b0;
                ent_rd_reg[i]    <= '0;
                ent_lat_reg[i]   <= '0;
            end
            sb_reg      <= '0;
            md_busy_reg <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_valid_reg[i] <= ent_valid_next[i];
                ent_wr_reg[i]    <= ent_wr_next[i];
                ent_rd_reg[i]    <= ent_rd_next[i];
                ent_lat_reg[i]   <= ent_lat_next[i];
            end
            sb_reg      <= sb_next;
            md_busy_reg <= md_busy_next;
        end
    end

endmodule

// File: tb/tb_vscale_hazard_unit.sv
// ---------------------------------------------------------------------------
// Testbench for vscale_hazard_unit (DEPTH = 2). Directed scenarios compare
// against fixed expected values; a randomized phase compares every output each
// cycle against a list-of-in-flight-instructions reference model.
// ---------------------------------------------------------------------------
module tb_vscale_hazard_unit;

    localparam int RW    = 5;
    localparam int DEPTH = 2;
    localparam int LW    = $clog2(DEPTH + 1);
    localparam int SW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          reset;
    logic          issue_valid;
    logic [RW-1:0] rs1_addr, rs2_addr;
    logic          uses_rs1, uses_rs2;
    logic          wr_reg_DX;
    logic [RW-1:0] rd_DX;
    logic [LW-1:0] lat_DX;
    logic          md_op_DX;
    logic          stall_ext;
    logic          flush;
    logic          md_done;
    logic [RW-1:0] md_rd;
    logic          stall_DX;
    logic          issue_fire;
    logic [SW-1:0] bypass_rs1_sel, bypass_rs2_sel;
    logic          wr_reg_WB;
    logic [RW-1:0] reg_to_wr_WB;
    logic          md_busy;

    vscale_hazard_unit #(.REG_ADDR_WIDTH(RW), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .issue_valid    (issue_valid),
        .rs1_addr       (rs1_addr),
        .rs2_addr       (rs2_addr),
        .uses_rs1       (uses_rs1),
        .uses_rs2       (uses_rs2),
        .wr_reg_DX      (wr_reg_DX),
        .rd_DX          (rd_DX),
        .lat_DX         (lat_DX),
        .md_op_DX       (md_op_DX),
        .stall_ext      (stall_ext),
        .flush          (flush),
        .md_done        (md_done),
        .md_rd          (md_rd),
        .stall_DX       (stall_DX),
        .issue_fire     (issue_fire),
        .bypass_rs1_sel (bypass_rs1_sel),
        .bypass_rs2_sel (bypass_rs2_sel),
        .wr_reg_WB      (wr_reg_WB),
        .reg_to_wr_WB   (reg_to_wr_WB),
        .md_busy        (md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- reference model ----------------
    // In-flight instructions by age: slot k = issued k+1 advances ago.
    typedef struct {
        bit v;
        bit wr;
        int rd;
        int lat;
    } inst_t;

    inst_t mp [DEPTH];
    bit    sb [32];
    bit    m_busy;
    int    m_pend_rd;

    int exp_sel1, exp_sel2, exp_rdwb;
    bit exp_stall, exp_fire, exp_wrwb, exp_busy;

    function automatic int src_sel(input bit use_src, input int a, inout bit raw);
        if (!use_src || a == 0) return 0;
        for (int k = 0; k < DEPTH; k++) begin
            if (mp[k].v && mp[k].wr && mp[k].rd == a) begin
                if (mp[k].lat <= k) return k + 1;
                raw = 1'b1;
                return 0;
            end
        end
        return 0;
    endfunction

    function automatic void model_eval();
        bit raw;
        bit sbs;
        raw      = 1'b0;
        exp_sel1 = src_sel(uses_rs1, int'(rs1_addr), raw);
        exp_sel2 = src_sel(uses_rs2, int'(rs2_addr), raw);
        sbs = (uses_rs1 && rs1_addr != 0 && sb[rs1_addr]) ||
              (uses_rs2 && rs2_addr != 0 && sb[rs2_addr]) ||
              ((wr_reg_DX || md_op_DX) && sb[rd_DX]) ||
              (md_op_DX && m_busy);
        exp_stall = (issue_valid && (raw || sbs)) || stall_ext;
        exp_fire  = issue_valid && !exp_stall;
        exp_wrwb  = mp[DEPTH-1].v && mp[DEPTH-1].wr && !stall_ext;
        exp_rdwb  = mp[DEPTH-1].rd;
        exp_busy  = m_busy;
    endfunction

    function automatic void model_clock();
        inst_t n;
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) mp[k] = '{0, 0, 0, 0};
            for (int r = 0; r < 32; r++) sb[r] = 0;
            m_busy = 0;
            return;
        end
        if (md_done) begin
            sb[md_rd] = 0;
            m_busy    = 0;
        end
        if (exp_fire && md_op_DX) begin
            sb[rd_DX] = 1;
            m_busy    = 1;
            m_pend_rd = int'(rd_DX);
        end
        if (flush) begin
            for (int k = 0; k < DEPTH; k++) mp[k].v = 0;
        end else if (!stall_ext) begin
            for (int k = DEPTH - 1; k > 0; k--) mp[k] = mp[k-1];
            n.v   = exp_fire;
            n.wr  = wr_reg_DX && !md_op_DX;
            n.rd  = int'(rd_DX);
            n.lat = (int'(lat_DX) > DEPTH - 1) ? DEPTH - 1 : int'(lat_DX);
            mp[0] = n;
        end
    endfunction

    // ---------------- stimulus plumbing ----------------
    task automatic drive(input bit iv, input int r1, input bit u1, input int r2,
                         input bit u2, input bit wr, input int rd, input int lat,
                         input bit md);
        issue_valid = iv;
        rs1_addr    = RW'(r1);
        uses_rs1    = u1;
        rs2_addr    = RW'(r2);
        uses_rs2    = u2;
        wr_reg_DX   = wr;
        rd_DX       = RW'(rd);
        lat_DX      = LW'(lat);
        md_op_DX    = md;
        stall_ext   = 1'b0;
        flush       = 1'b0;
        md_done     = 1'b0;
        md_rd       = '0;
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic drain();
        for (int k = 0; k < DEPTH + 1; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
            settle();
            tick();
        end
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        settle();
        tick();
        tick();
        reset = 1'b0;
        settle();
        $display("reset: stall=%0b fire=%0b sel=%0d/%0d wb=%0b busy=%0b",
                 stall_DX, issue_fire, bypass_rs1_sel, bypass_rs2_sel, wr_reg_WB, md_busy);
        checks++;
        if ({stall_DX, issue_fire, bypass_rs1_sel, bypass_rs2_sel, wr_reg_WB, reg_to_wr_WB, md_busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got stall=%0b fire=%0b sel1=%0d sel2=%0d wb=%0b rd=%0d busy=%0b want all 0",
                     stall_DX, issue_fire, bypass_rs1_sel, bypass_rs2_sel, wr_reg_WB, reg_to_wr_WB, md_busy);
        end
        tick();
    endtask

    task automatic test_alu_bypass();
        drain();
        drive(1, 0, 0, 0, 0, 1, 5, 0, 0);   // add x5
        settle();
        $display("alu: add x5 fire=%0b", issue_fire);
        checks++;
        if (issue_fire !== 1'b1) begin errors++; $display("FAIL alu_fire got %0b want 1", issue_fire); end
        tick();
        drive(1, 5, 1, 0, 1, 1, 6, 0, 0);   // add x6,x5,x0
        settle();
        $display("alu: add x6,x5,x0 sel1=%0d sel2=%0d stall=%0b", bypass_rs1_sel, bypass_rs2_sel, stall_DX);
        checks++;
        if (bypass_rs1_sel !== 2'd1) begin errors++; $display("FAIL alu_b2b_sel1 got %0d want 1", bypass_rs1_sel); end
        checks++;
        if (bypass_rs2_sel !== 2'd0) begin errors++; $display("FAIL alu_x0_sel2 got %0d want 0", bypass_rs2_sel); end
        checks++;
        if (stall_DX !== 1'b0) begin errors++; $display("FAIL alu_b2b_stall got %0b want 0", stall_DX); end
        tick();
        drive(1, 5, 1, 0, 0, 0, 0, 0, 0);   // consumer of x5, two behind
        settle();
        $display("alu: consumer x5 sel1=%0d", bypass_rs1_sel);
        checks++;
        if (bypass_rs1_sel !== 2'd2) begin errors++; $display("FAIL alu_dist2_sel1 got %0d want 2", bypass_rs1_sel); end
        tick();
    endtask

    task automatic test_load_use();
        drain();
        drive(1, 0, 0, 0, 0, 1, 7, 1, 0);   // lw x7
        settle();
        $display("load: lw x7 fire=%0b", issue_fire);
        tick();
        drive(1, 7, 1, 7, 1, 1, 8, 0, 0);   // add x8,x7,x7
        settle();
        $display("load: add x8 stall=%0b fire=%0b", stall_DX, issue_fire);
        checks++;
        if (stall_DX !== 1'b1) begin errors++; $display("FAIL load_use_stall got %0b want 1", stall_DX); end
        checks++;
        if (issue_fire !== 1'b0) begin errors++; $display("FAIL load_use_fire got %0b want 0", issue_fire); end
        tick();
        settle();
        $display("load: add x8 retry sel=%0d/%0d fire=%0b", bypass_rs1_sel, bypass_rs2_sel, issue_fire);
        checks++;
        if (bypass_rs1_sel !== 2'd2 || bypass_rs2_sel !== 2'd2) begin
            errors++;
            $display("FAIL load_bypass_sel got %0d/%0d want 2/2", bypass_rs1_sel, bypass_rs2_sel);
        end
        checks++;
        if (issue_fire !== 1'b1) begin errors++; $display("FAIL load_retry_fire got %0b want 1", issue_fire); end
        tick();
    endtask

    task automatic test_x0_and_unused();
        drain();
        drive(1, 0, 0, 0, 0, 1, 0, 0, 0);   // add x0
        settle();
        tick();
        drive(1, 0, 1, 0, 1, 1, 3, 0, 0);   // reads x0, writes x3
        settle();
        $display("x0: sel=%0d/%0d stall=%0b", bypass_rs1_sel, bypass_rs2_sel, stall_DX);
        checks++;
        if (bypass_rs1_sel !== 2'd0 || bypass_rs2_sel !== 2'd0 || stall_DX !== 1'b0) begin
            errors++;
            $display("FAIL x0_consumer got sel=%0d/%0d stall=%0b want 0/0/0", bypass_rs1_sel, bypass_rs2_sel, stall_DX);
        end
        tick();
        drive(1, 3, 0, 0, 0, 0, 0, 0, 0);   // rs1=x3 but not used
        settle();
        $display("unused: sel1=%0d", bypass_rs1_sel);
        checks++;
        if (bypass_rs1_sel !== 2'd0) begin errors++; $display("FAIL unused_src_sel1 got %0d want 0", bypass_rs1_sel); end
        tick();
    endtask

    task automatic test_stall_ext();
        drain();
        drive(1, 0, 0, 0, 0, 1, 12, 0, 0);  // add x12
        settle();
        tick();
        for (int c = 0; c < 3; c++) begin
            drive(1, 12, 1, 0, 0, 0, 0, 0, 0);
            stall_ext = 1'b1;
            settle();
            $display("stall_ext c%0d: stall=%0b fire=%0b wb=%0b sel1=%0d", c, stall_DX, issue_fire, wr_reg_WB, bypass_rs1_sel);
            checks++;
            if (stall_DX !== 1'b1 || issue_fire !== 1'b0 || wr_reg_WB !== 1'b0) begin
                errors++;
                $display("FAIL stall_ext_hold c%0d got stall=%0b fire=%0b wb=%0b want 1/0/0", c, stall_DX, issue_fire, wr_reg_WB);
            end
            checks++;
            if (bypass_rs1_sel !== 2'd1) begin errors++; $display("FAIL stall_ext_entry_hold c%0d got sel1=%0d want 1", c, bypass_rs1_sel); end
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        settle();
        tick();
        settle();
        $display("stall_ext release: wb=%0b rd=%0d", wr_reg_WB, reg_to_wr_WB);
        checks++;
        if (wr_reg_WB !== 1'b1 || reg_to_wr_WB !== 5'd12) begin
            errors++;
            $display("FAIL stall_ext_wb got wb=%0b rd=%0d want 1/12", wr_reg_WB, reg_to_wr_WB);
        end
        tick();
    endtask

    task automatic test_flush();
        drain();
        drive(1, 0, 0, 0, 0, 1, 9, 0, 0);
        settle();
        tick();
        drive(1, 0, 0, 0, 0, 1, 9, 0, 0);
        settle();
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        flush = 1'b1;
        settle();
        tick();
        drive(1, 9, 1, 0, 0, 0, 0, 0, 0);
        settle();
        $display("flush: sel1=%0d wb=%0b stall=%0b", bypass_rs1_sel, wr_reg_WB, stall_DX);
        checks++;
        if (bypass_rs1_sel !== 2'd0 || wr_reg_WB !== 1'b0 || stall_DX !== 1'b0) begin
            errors++;
            $display("FAIL flush_kill got sel1=%0d wb=%0b stall=%0b want 0/0/0", bypass_rs1_sel, wr_reg_WB, stall_DX);
        end
        tick();
    endtask

    task automatic test_md();
        drain();
        drive(1, 0, 0, 0, 0, 1, 10, 0, 1);  // div x10
        settle();
        $display("md: div x10 fire=%0b", issue_fire);
        checks++;
        if (issue_fire !== 1'b1) begin errors++; $display("FAIL md_issue_fire got %0b want 1", issue_fire); end
        tick();
        drive(1, 10, 1, 0, 0, 0, 0, 0, 0);
        settle();
        $display("md: consumer busy=%0b stall=%0b", md_busy, stall_DX);
        checks++;
        if (md_busy !== 1'b1) begin errors++; $display("FAIL md_busy_set got %0b want 1", md_busy); end
        checks++;
        if (stall_DX !== 1'b1) begin errors++; $display("FAIL md_raw_stall got %0b want 1", stall_DX); end
        tick();
        drive(1, 0, 0, 0, 0, 1, 11, 0, 1);  // second md op
        settle();
        $display("md: second md stall=%0b wb=%0b", stall_DX, wr_reg_WB);
        checks++;
        if (stall_DX !== 1'b1) begin errors++; $display("FAIL md_busy_stall got %0b want 1", stall_DX); end
        checks++;
        if (wr_reg_WB !== 1'b0) begin errors++; $display("FAIL md_no_wb got %0b want 0", wr_reg_WB); end
        tick();
        drive(1, 10, 1, 0, 0, 0, 0, 0, 0);
        md_done = 1'b1;
        md_rd   = 5'd10;
        settle();
        $display("md: done cycle stall=%0b", stall_DX);
        checks++;
        if (stall_DX !== 1'b1) begin errors++; $display("FAIL md_done_cycle_stall got %0b want 1", stall_DX); end
        tick();
        drive(1, 10, 1, 0, 0, 0, 0, 0, 0);
        settle();
        $display("md: after done fire=%0b sel1=%0d busy=%0b", issue_fire, bypass_rs1_sel, md_busy);
        checks++;
        if (issue_fire !== 1'b1 || bypass_rs1_sel !== 2'd0 || md_busy !== 1'b0) begin
            errors++;
            $display("FAIL md_release got fire=%0b sel1=%0d busy=%0b want 1/0/0", issue_fire, bypass_rs1_sel, md_busy);
        end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 3) != 0,
                  $urandom_range(0, 7), $urandom_range(0, 1),
                  $urandom_range(0, 7), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 7),
                  $urandom_range(0, 3), $urandom_range(0, 7) == 0);
            stall_ext = ($urandom_range(0, 7) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            if (m_busy && $urandom_range(0, 2) == 0) begin
                md_done = 1'b1;
                md_rd   = RW'(m_pend_rd);
            end
            reset = ($urandom_range(0, 199) == 0);
            settle();
            $display("rnd %0d: iv=%0b rs=%0d/%0d rd=%0d md=%0b -> stall=%0b fire=%0b sel=%0d/%0d wb=%0b",
                     c, issue_valid, rs1_addr, rs2_addr, rd_DX, md_op_DX,
                     stall_DX, issue_fire, bypass_rs1_sel, bypass_rs2_sel, wr_reg_WB);
            checks++;
            if (stall_DX !== exp_stall) begin errors++; $display("FAIL rnd_stall c%0d got %0b want %0b", c, stall_DX, exp_stall); end
            checks++;
            if (issue_fire !== exp_fire) begin errors++; $display("FAIL rnd_fire c%0d got %0b want %0b", c, issue_fire, exp_fire); end
            checks++;
            if (int'(bypass_rs1_sel) != exp_sel1) begin errors++; $display("FAIL rnd_sel1 c%0d got %0d want %0d", c, bypass_rs1_sel, exp_sel1); end
            checks++;
            if (int'(bypass_rs2_sel) != exp_sel2) begin errors++; $display("FAIL rnd_sel2 c%0d got %0d want %0d", c, bypass_rs2_sel, exp_sel2); end
            checks++;
            if (wr_reg_WB !== exp_wrwb) begin errors++; $display("FAIL rnd_wb c%0d got %0b want %0b", c, wr_reg_WB, exp_wrwb); end
            checks++;
            if (md_busy !== exp_busy) begin errors++; $display("FAIL rnd_busy c%0d got %0b want %0b", c, md_busy, exp_busy); end
            if (exp_wrwb) begin
                checks++;
                if (int'(reg_to_wr_WB) != exp_rdwb) begin errors++; $display("FAIL rnd_wb_rd c%0d got %0d want %0d", c, reg_to_wr_WB, exp_rdwb); end
            end
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        m_busy    = 0;
        m_pend_rd = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        test_reset();
        test_alu_bypass();
        test_load_use();
        test_x0_and_unused();
        test_stall_ext();
        test_flush();
        test_md();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
